// File: rtl/cp0_reg_file_pkg.sv
// Shared CP0 definitions: register map, ExcCodes, Status/Cause fields, write masks.
// Optional timer interrupt: define CP0_TIMER_INT_EN.
package cp0_reg_file_pkg;

    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int ST_IE   = 0;
    localparam int ST_EXL  = 1;
    localparam int CA_BD   = 31;
    localparam int CA_TI   = 30;
    localparam int CA_IP7  = 15;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_BADVADDR,
        REG_COUNT,
        REG_COMPARE,
        REG_STATUS,
        REG_CAUSE,
        REG_EPC
    } cp0_reg_e;

    function automatic cp0_reg_e cp0_decode(input logic [7:0] addr);
        cp0_reg_e r;
        r = REG_NONE;
        if (addr[2:0] == 3'd0) begin
            case (addr[7:3])
                RD_BADVADDR: r = REG_BADVADDR;
                RD_COUNT:    r = REG_COUNT;
                RD_COMPARE:  r = REG_COMPARE;
                RD_STATUS:   r = REG_STATUS;
                RD_CAUSE:    r = REG_CAUSE;
                RD_EPC:      r = REG_EPC;
                default:     r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_reg_file_if.sv
// mtc0/mfc0 access bus between the pipeline (master) and CP0 (slave).
// Optional timer interrupt: define CP0_TIMER_INT_EN.
interface cp0_reg_file_if;
    logic        cp0_write_en;
    logic        cp0_read_en;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_write_data;
    logic [31:0] cp0_read_data;

    modport master (
        output cp0_write_en, cp0_read_en, cp0_addr, cp0_write_data,
        input  cp0_read_data
    );

    modport slave (
        input  cp0_write_en, cp0_read_en, cp0_addr, cp0_write_data,
        output cp0_read_data
    );
endinterface

// File: rtl/cp0_reg_file_timer.sv
// Count/Compare timer: clock divider, free-running Count, sticky TI on match.
// TI is only generated when CP0_TIMER_INT_EN is defined.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        count_d   = count_q;
        compare_d = compare_q;
        // A software write to Count overrides this cycle's increment
        if (wr_count)
            count_d = wdata;
        else if (tick)
            count_d = count_q + 32'd1;
        if (wr_compare)
            compare_d = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic ti_q, ti_d;

    // Match uses pre-update values; Compare write clears even on a match
    always_comb begin
        ti_d = ti_q | (count_q == compare_q);
        if (wr_compare)
            ti_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ti_q <= 1'b0;
        else
            ti_q <= ti_d;
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    assign count   = count_q;
    assign compare = compare_q;

endmodule

// File: rtl/cp0_reg_file.sv
// CP0 register file: mtc0/mfc0 access, exception/eret state, interrupt request.
// Optional timer interrupt: define CP0_TIMER_INT_EN.
module cp0_reg_file
    import cp0_reg_file_pkg::*;
#(
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    cp0_reg_file_if.slave cp0,
    input  logic [5:0]  hw_int,
    input  logic        exc_en,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic [31:0] exc_bad_vaddr,
    input  logic        eret_en,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pending
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] count, compare;
    logic        ti;
    cp0_reg_e    sel;
    logic        wr;
    logic        wr_status, wr_cause, wr_epc;
    logic        wr_count, wr_compare;

    assign sel = cp0_decode(cp0.cp0_addr);
    // mtc0 is dropped whenever an exception or eret commits
    assign wr  = cp0.cp0_write_en & ~exc_en & ~eret_en;

    assign wr_status  = wr && (sel == REG_STATUS);
    assign wr_cause   = wr && (sel == REG_CAUSE);
    assign wr_epc     = wr && (sel == REG_EPC);
    assign wr_count   = wr && (sel == REG_COUNT);
    assign wr_compare = wr && (sel == REG_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wdata      (cp0.cp0_write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badv_d   = badv_q;
        cause_d[15:10] = hw_int;
        if (exc_en) begin
            if (!status_q[ST_EXL]) begin
                epc_d = exc_delay_slot ? exc_pc - 32'd4 : exc_pc;
                cause_d[CA_BD] = exc_delay_slot;
            end
            status_d[ST_EXL] = 1'b1;
            cause_d[6:2] = exc_code;
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                badv_d = exc_bad_vaddr;
        end else if (eret_en) begin
            status_d[ST_EXL] = 1'b0;
        end else begin
            unique case (1'b1)
                wr_status: status_d = (status_q & ~STATUS_WMASK)
                                    | (cp0.cp0_write_data & STATUS_WMASK);
                wr_cause:  cause_d[9:8] = cp0.cp0_write_data[9:8];
                wr_epc:    epc_d = cp0.cp0_write_data;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= STATUS_RESET;
            cause_q  <= '0;
            epc_q    <= '0;
            badv_q   <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
        end
    end

    // TI lives in the timer; fold it into Cause.TI and Cause.IP7 on read
    always_comb begin
        cause = cause_q;
        cause[CA_TI]  = ti;
        cause[CA_IP7] = cause_q[CA_IP7] | ti;
    end

    assign status = status_q;
    assign epc    = epc_q;

    assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL]
                       & |(cause[15:8] & status_q[15:8]);

    always_comb begin
        cp0.cp0_read_data = '0;
        if (cp0.cp0_read_en) begin
            unique case (sel)
                REG_BADVADDR: cp0.cp0_read_data = badv_q;
                REG_COUNT:    cp0.cp0_read_data = count;
                REG_COMPARE:  cp0.cp0_read_data = compare;
                REG_STATUS:   cp0.cp0_read_data = status_q;
                REG_CAUSE:    cp0.cp0_read_data = cause;
                REG_EPC:      cp0.cp0_read_data = epc_q;
                default:      cp0.cp0_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_reg_file.sv
// Self-checking bench for cp0_reg_file (COUNT_DIV=2); expected values queued
// at stimulus time and popped when the DUT output is sampled.
module tb_cp0_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic        exc_en;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic [31:0] exc_bad_vaddr;
    logic        eret_en;
    logic [31:0] status, cause, epc;
    logic        int_pending;

    logic [31:0] exp_q[$];
    logic [31:0] got, e;
    int          n_chk = 0;
    int          n_err = 0;

    cp0_reg_file_if cp0_bus ();

    cp0_reg_file #(
        .COUNT_DIV    (2),
        .STATUS_RESET (32'h0040_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cp0            (cp0_bus),
        .hw_int         (hw_int),
        .exc_en         (exc_en),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_delay_slot (exc_delay_slot),
        .exc_bad_vaddr  (exc_bad_vaddr),
        .eret_en        (eret_en),
        .status         (status),
        .cause          (cause),
        .epc            (epc),
        .int_pending    (int_pending)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] rd, input logic [31:0] d);
        cp0_bus.cp0_write_en   = 1'b1;
        cp0_bus.cp0_addr       = {rd, 3'b000};
        cp0_bus.cp0_write_data = d;
        @(negedge clk);
        cp0_bus.cp0_write_en   = 1'b0;
    endtask

    task automatic mfc0(input logic [7:0] a, output logic [31:0] v);
        cp0_bus.cp0_read_en = 1'b1;
        cp0_bus.cp0_addr    = a;
        #1;
        v = cp0_bus.cp0_read_data;
        cp0_bus.cp0_read_en = 1'b0;
    endtask

    task automatic exc(input logic [4:0] c, input logic [31:0] pc,
                       input logic ds, input logic [31:0] va);
        exc_en = 1'b1; exc_code = c; exc_pc = pc;
        exc_delay_slot = ds; exc_bad_vaddr = va;
        @(negedge clk);
        exc_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0040_0000);
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL rst_status got=%h exp=%h", status, e); end
        e = exp_q.pop_front(); n_chk++;
        if (cause !== e) begin n_err++; $display("FAIL rst_cause got=%h exp=%h", cause, e); end
        e = exp_q.pop_front(); n_chk++;
        if (epc !== e) begin n_err++; $display("FAIL rst_epc got=%h exp=%h", epc, e); end
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL rst_int got=%b exp=%h", int_pending, e); end
        mfc0({5'd12, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL rst_rd_status got=%h exp=%h", got, e); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_masks;
        mtc0(5'd12, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0040_FF03);
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL status_mask got=%h exp=%h", status, e); end
        mtc0(5'd12, 32'h0);
        mtc0(5'd8, 32'h1234);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        mfc0({5'd8, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL badvaddr_ro got=%h exp=%h", got, e); end
        mfc0({5'd12, 3'd1}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL unmapped_sel got=%h exp=%h", got, e); end
        cp0_bus.cp0_addr = {5'd12, 3'd0};
        #1 got = cp0_bus.cp0_read_data;
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL rd_disabled got=%h exp=%h", got, e); end
    endtask

    task automatic test_exception;
        exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h3);
        exp_q.push_back(32'hBFC0_00FC);
        exp_q.push_back({1'b1, 24'b0, 5'd4, 2'b0});
        exp_q.push_back(32'h0040_0002);
        exp_q.push_back(32'h3);
        e = exp_q.pop_front(); n_chk++;
        if (epc !== e) begin n_err++; $display("FAIL exc_epc got=%h exp=%h", epc, e); end
        e = exp_q.pop_front(); n_chk++;
        if ((cause & 32'h8000_007C) !== e) begin n_err++; $display("FAIL exc_cause got=%h exp=%h", cause, e); end
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL exc_exl got=%h exp=%h", status, e); end
        mfc0({5'd8, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL exc_badv got=%h exp=%h", got, e); end
        exc(5'd12, 32'h0000_0200, 1'b0, 32'h77);
        exp_q.push_back(32'hBFC0_00FC);
        exp_q.push_back({1'b1, 24'b0, 5'd12, 2'b0});
        exp_q.push_back(32'h3);
        e = exp_q.pop_front(); n_chk++;
        if (epc !== e) begin n_err++; $display("FAIL exc2_epc got=%h exp=%h", epc, e); end
        e = exp_q.pop_front(); n_chk++;
        if ((cause & 32'h8000_007C) !== e) begin n_err++; $display("FAIL exc2_cause got=%h exp=%h", cause, e); end
        mfc0({5'd8, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL exc2_badv got=%h exp=%h", got, e); end
        eret_en = 1'b1;
        cyc(1);
        eret_en = 1'b0;
        exp_q.push_back(32'h0040_0000);
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL eret_exl got=%h exp=%h", status, e); end
    endtask

    task automatic test_timer;
        logic ti_exp;
        logic ip_exp;
`ifdef CP0_TIMER_INT_EN
        ti_exp = 1'b1;
`else
        ti_exp = 1'b0;
`endif
        mtc0(5'd11, 32'd5);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, cause[30]} !== e) begin n_err++; $display("FAIL cmp_clear got=%b exp=%h", cause[30], e); end
        mtc0(5'd9, 32'd0);
        cyc(10);
        exp_q.push_back(32'd5);
        mfc0({5'd9, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL count_rate got=%h exp=%h", got, e); end
        exp_q.push_back({31'b0, ti_exp});
        for (int i = 0; i < 30 && cause[30] !== ti_exp; i++) cyc(1);
        if (!ti_exp) cyc(20);
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, cause[30]} !== e) begin n_err++; $display("FAIL ti_set got=%b exp=%h", cause[30], e); end
        mtc0(5'd12, 32'h0000_8001);
        ip_exp = ti_exp;
        exp_q.push_back({31'b0, ip_exp});
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL timer_int got=%b exp=%h", int_pending, e); end
        mtc0(5'd11, 32'd100);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, cause[30]} !== e) begin n_err++; $display("FAIL ti_clear got=%b exp=%h", cause[30], e); end
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL ti_int_clr got=%b exp=%h", int_pending, e); end
    endtask

    task automatic test_priority;
        exc_en = 1'b1; exc_code = 5'd8; exc_pc = 32'h400;
        exc_delay_slot = 1'b0; exc_bad_vaddr = 32'h0;
        mtc0(5'd14, 32'hDEAD);
        exc_en = 1'b0;
        exp_q.push_back(32'h0000_0400);
        exp_q.push_back(32'h0040_8003);
        e = exp_q.pop_front(); n_chk++;
        if (epc !== e) begin n_err++; $display("FAIL exc_over_mtc0 got=%h exp=%h", epc, e); end
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL exc_status got=%h exp=%h", status, e); end
        eret_en = 1'b1;
        mtc0(5'd12, 32'hFFFF_FFFF);
        eret_en = 1'b0;
        exp_q.push_back(32'h0040_8001);
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL eret_over_mtc0 got=%h exp=%h", status, e); end
    endtask

    task automatic test_wrap;
        mtc0(5'd9, 32'hFFFF_FFFF);
        cyc(2);
        exp_q.push_back(32'h0);
        mfc0({5'd9, 3'd0}, got);
        e = exp_q.pop_front(); n_chk++;
        if (got !== e) begin n_err++; $display("FAIL count_wrap got=%h exp=%h", got, e); end
    endtask

    task automatic test_hw_int;
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        cyc(1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, cause[10]} !== e) begin n_err++; $display("FAIL hw_ip2 got=%b exp=%h", cause[10], e); end
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL hw_int got=%b exp=%h", int_pending, e); end
        hw_int = 6'b0;
        cyc(1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL hw_int_off got=%b exp=%h", int_pending, e); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd12, 32'h0000_0101);
        exp_q.push_back(32'h0000_0320);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_chk++;
        if ((cause & 32'h8000_FF7C) !== e) begin n_err++; $display("FAIL cause_mask got=%h exp=%h", cause, e); end
        e = exp_q.pop_front(); n_chk++;
        if ({31'b0, int_pending} !== e) begin n_err++; $display("FAIL sw_int got=%b exp=%h", int_pending, e); end
    endtask

    task automatic test_reset_mid;
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0040_0000);
        e = exp_q.pop_front(); n_chk++;
        if (epc !== e) begin n_err++; $display("FAIL async_rst_epc got=%h exp=%h", epc, e); end
        e = exp_q.pop_front(); n_chk++;
        if (status !== e) begin n_err++; $display("FAIL async_rst_status got=%h exp=%h", status, e); end
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        hw_int = '0;
        exc_en = 1'b0; exc_code = '0; exc_pc = '0;
        exc_delay_slot = 1'b0; exc_bad_vaddr = '0;
        eret_en = 1'b0;
        cp0_bus.cp0_write_en = 1'b0;
        cp0_bus.cp0_read_en = 1'b0;
        cp0_bus.cp0_addr = '0;
        cp0_bus.cp0_write_data = '0;
        @(negedge clk);
        test_reset;
        test_masks;
        test_exception;
        test_timer;
        test_priority;
        test_wrap;
        test_hw_int;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
